sd_sector_cache: RTL and testbench
==================================

SD_SECTOR_CACHE -- requirements
Module: sd_sector_cache

Interface
REQ-001 SHALL have the following ports, clock and reset first: clk  in  1  system clock; all logic on the rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have upstream request ports from the instruction dispatcher: sd_read  in  1  byte read request; sd_write  in  1  byte write request; sd_addr  in  32  byte address; sd_write_data  in  8  write byte.
REQ-004 SHALL have upstream response ports: sd_read_data  out  8  read byte; sd_ready  out  1  one-cycle completion pulse.
REQ-005 SHALL have downstream ports to the SPI sector controller:
- blk_addr  out  23  sector number, sd_addr[31:9]
- blk_cmd_rd  out  1  one-cycle sector read command
- blk_cmd_wr  out  1  one-cycle sector write command
- blk_idle  in  1  controller accepts a command
- blk_rx_valid  in  1  blk_rx_data valid
- blk_rx_data  in  8  read byte stream
- blk_tx_req  in  1  controller requests the next write byte
- blk_tx_data  out  8  write byte
- blk_err  in  1  transfer failed

Function
REQ-006 SHALL hold one 512-byte sector buffer with tag[22:0], valid bit and dirty bit.
REQ-007 SHALL implement states IDLE, LOOKUP, WB_CMD, WB_XFER, FILL_CMD, FILL_XFER, RESPOND.
REQ-008 IDLE: on sd_read or sd_write, SHALL latch address, data and op, then go to LOOKUP; if both are high, read wins.
REQ-009 LOOKUP, hit (valid and tag == addr[31:9]): SHALL go to RESPOND; a write stores the byte at addr[8:0] and sets dirty.
REQ-010 LOOKUP, miss: SHALL go to WB_CMD if dirty, otherwise to FILL_CMD.
REQ-011 Read-hit latency SHALL be exactly 2 cycles: request sampled in cycle N, sd_ready high in cycle N+2; write hit is the same.
REQ-012 WB_CMD: SHALL wait for blk_idle, then pulse blk_cmd_wr for one cycle with blk_addr = old tag, and go to WB_XFER.
REQ-013 WB_XFER: for the k-th blk_tx_req, SHALL present buffer byte k-1 on blk_tx_data in the following cycle.
REQ-014 WB_XFER: after the 512th byte and the return of blk_idle, SHALL clear dirty and go to FILL_CMD.
REQ-015 FILL_CMD: SHALL wait for blk_idle, then pulse blk_cmd_rd for one cycle with blk_addr = new sector, and go to FILL_XFER.
REQ-016 FILL_XFER: SHALL store each blk_rx_valid byte at an incrementing index 0..511; bytes beyond 512 are ignored.
REQ-017 FILL_XFER: after byte 511, SHALL set tag, set valid and re-enter LOOKUP, which then hits.
REQ-018 RESPOND: SHALL drive sd_ready = 1 for exactly one cycle; sd_read_data = buffer byte for reads, unchanged for writes; then go to IDLE.
REQ-019 The cycle after sd_ready SHALL be IDLE, and a still-asserted request is treated as a new access (back-to-back instructions).
REQ-020 sd_read_data SHALL hold its value until the next RESPOND.
REQ-021 blk_err in WB_XFER or FILL_XFER SHALL clear valid and dirty, set sd_read_data = 8'hFF, and go to RESPOND; blk_err in other states is ignored.
REQ-022 Byte counter SHALL be 9 bits; wrap from 511 to 0 marks the end of a transfer.
REQ-023 At most one blk_cmd_rd/blk_cmd_wr SHALL be issued per FILL_CMD/WB_CMD entry; the two are never high together.

Reset
REQ-024 On reset, SHALL go to IDLE; clear valid, dirty and tag; set sd_read_data = 0, sd_ready = 0, blk_cmd_rd = 0, blk_cmd_wr = 0, blk_addr = 0, blk_tx_data = 0; buffer contents are undefined.
REQ-025 Reset during any transfer SHALL abandon it without further commands; the downstream controller shares the same reset.

Configuration
REQ-026 SD_CACHE_WRITEBACK_EN defined: writes behave as in REQ-009 to REQ-014.
REQ-027 SD_CACHE_WRITEBACK_EN undefined: WB_CMD, WB_XFER and dirty are absent; blk_cmd_wr and blk_tx_data are tied to 0; sd_write completes via RESPOND 2 cycles after the request without touching buffer or card.

Verification
REQ-028 Reset, then sd_read addr 0x00000203 -> blk_cmd_rd with blk_addr = 1; 512 bytes (byte i = i[7:0]) fed; sd_ready once with sd_read_data = 0x03.
REQ-029 Following sd_read addr 0x000002FF, held through the ready -> two sd_ready pulses, each 2 cycles after its request, data 0xFF; no blk_cmd_rd.
REQ-030 (WRITEBACK_EN) sd_write addr 0x205, data 0xA5 (hit), then sd_read addr 0x400 -> blk_cmd_wr with blk_addr = 1; tx byte 5 = 0xA5; then blk_cmd_rd with blk_addr = 2.
REQ-031 blk_err asserted at fill byte 100 -> sd_ready with 0xFF; next read of the same sector re-issues blk_cmd_rd.
REQ-032 Reset asserted mid-FILL_XFER (byte 300) -> outputs at reset values next cycle; next read issues a fresh blk_cmd_rd.
REQ-033 sd_read and sd_write both high on a hit -> read performed; buffer unchanged; dirty unchanged.

Source files
------------

// File: rtl/sd_sector_cache.sv
// sd_sector_cache: single-sector (512 B) byte cache between the instruction
// dispatcher and an SPI sector controller.
//
// Optional feature macro: SD_CACHE_WRITEBACK_EN
//   defined   : writes update the cached sector, mark it dirty, and a dirty
//               sector is written back to the card before a new one is fetched.
//   undefined : writes complete after two cycles without touching buffer or
//               card; blk_cmd_wr and blk_tx_data are held at zero.
//
// Ports
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   sd_read, sd_write       : byte read / write request (read wins if both)
//   sd_addr, sd_write_data  : byte address (sector = [31:9], offset = [8:0]), write byte
//   sd_read_data, sd_ready  : read byte (held until next response), one-cycle done pulse
//   blk_addr                : sector number for the current card command
//   blk_cmd_rd, blk_cmd_wr  : one-cycle sector read / write commands
//   blk_idle                : controller can accept a command
//   blk_rx_valid/_data      : incoming sector byte stream
//   blk_tx_req, blk_tx_data : write byte request / byte presented the cycle after
//   blk_err                 : transfer failure

module sd_sector_cache (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_read,
  input  logic        sd_write,
  input  logic [31:0] sd_addr,
  input  logic [7:0]  sd_write_data,
  output logic [7:0]  sd_read_data,
  output logic        sd_ready,
  output logic [22:0] blk_addr,
  output logic        blk_cmd_rd,
  output logic        blk_cmd_wr,
  input  logic        blk_idle,
  input  logic        blk_rx_valid,
  input  logic [7:0]  blk_rx_data,
  input  logic        blk_tx_req,
  output logic [7:0]  blk_tx_data,
  input  logic        blk_err
);

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned IDX_W        = 9;
  localparam int unsigned TAG_W        = ADDR_W - IDX_W;
  localparam int unsigned SECTOR_BYTES = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_BYTES - 1);

`ifdef SD_CACHE_WRITEBACK_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    FILL_CMD  = 3'd2,
    FILL_XFER = 3'd3,
    RESPOND   = 3'd4,
    WB_CMD    = 3'd5,
    WB_XFER   = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    FILL_CMD  = 3'd2,
    FILL_XFER = 3'd3,
    RESPOND   = 3'd4
  } state_e;
`endif

  state_e              state_q;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [TAG_W-1:0]    tag_q;
  logic                valid_q;
  logic [IDX_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                cmd_rd_q;
  logic [TAG_W-1:0]    blk_addr_q;
  logic [DATA_W-1:0]   sector_q [SECTOR_BYTES];

`ifdef SD_CACHE_WRITEBACK_EN
  logic [DATA_W-1:0]   wdata_q;
  logic                dirty_q;
  logic                cmd_wr_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_done_q;
`else
  logic                unused_wr_path;
  assign unused_wr_path = ^{sd_write_data, blk_tx_req};
`endif

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic                lookup_hit;
  logic [IDX_W-1:0]    cnt_d;

  assign req_tag    = addr_q[ADDR_W-1:IDX_W];
  assign req_idx    = addr_q[IDX_W-1:0];
  assign lookup_hit = valid_q && (tag_q == req_tag);
  // 9-bit counter: 511 + 1 wraps to 0, which closes a transfer
  assign cnt_d      = cnt_q + IDX_W'(1);

  // Control FSM, sector buffer and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      cmd_rd_q   <= 1'b0;
      blk_addr_q <= '0;
`ifdef SD_CACHE_WRITEBACK_EN
      wdata_q    <= '0;
      dirty_q    <= 1'b0;
      cmd_wr_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_done_q  <= 1'b0;
`endif
    end else begin
      // Pulsed outputs default low
      ready_q  <= 1'b0;
      cmd_rd_q <= 1'b0;
`ifdef SD_CACHE_WRITEBACK_EN
      cmd_wr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (sd_read || sd_write) begin
            addr_q  <= sd_addr;
            op_wr_q <= !sd_read;
`ifdef SD_CACHE_WRITEBACK_EN
            wdata_q <= sd_write_data;
`endif
            state_q <= LOOKUP;
          end
        end

        LOOKUP: begin
`ifdef SD_CACHE_WRITEBACK_EN
          if (lookup_hit) begin
            if (op_wr_q) begin
              sector_q[req_idx] <= wdata_q;
              dirty_q           <= 1'b1;
            end else begin
              rdata_q <= sector_q[req_idx];
            end
            ready_q <= 1'b1;
            state_q <= RESPOND;
          end else if (dirty_q) begin
            state_q <= WB_CMD;
          end else begin
            state_q <= FILL_CMD;
          end
`else
          // Writes are acknowledged without touching buffer or card
          if (op_wr_q) begin
            ready_q <= 1'b1;
            state_q <= RESPOND;
          end else if (lookup_hit) begin
            rdata_q <= sector_q[req_idx];
            ready_q <= 1'b1;
            state_q <= RESPOND;
          end else begin
            state_q <= FILL_CMD;
          end
`endif
        end

`ifdef SD_CACHE_WRITEBACK_EN
        WB_CMD: begin
          if (blk_idle) begin
            cmd_wr_q   <= 1'b1;
            blk_addr_q <= tag_q;
            cnt_q      <= '0;
            tx_done_q  <= 1'b0;
            state_q    <= WB_XFER;
          end
        end

        WB_XFER: begin
          if (blk_err) begin
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            rdata_q <= 8'hFF;
            ready_q <= 1'b1;
            state_q <= RESPOND;
          end else if (tx_done_q) begin
            // All bytes handed over; wait for the controller to finish programming
            if (blk_idle) begin
              dirty_q <= 1'b0;
              state_q <= FILL_CMD;
            end
          end else if (blk_tx_req) begin
            tx_data_q <= sector_q[cnt_q];
            cnt_q     <= cnt_d;
            if (cnt_q == LAST_IDX) begin
              tx_done_q <= 1'b1;
            end
          end
        end
`endif

        FILL_CMD: begin
          if (blk_idle) begin
            cmd_rd_q   <= 1'b1;
            blk_addr_q <= req_tag;
            cnt_q      <= '0;
            // Buffer is about to be overwritten; old contents no longer valid
            valid_q    <= 1'b0;
            state_q    <= FILL_XFER;
          end
        end

        FILL_XFER: begin
          if (blk_err) begin
            valid_q <= 1'b0;
`ifdef SD_CACHE_WRITEBACK_EN
            dirty_q <= 1'b0;
`endif
            rdata_q <= 8'hFF;
            ready_q <= 1'b1;
            state_q <= RESPOND;
          end else if (blk_rx_valid) begin
            sector_q[cnt_q] <= blk_rx_data;
            cnt_q           <= cnt_d;
            if (cnt_q == LAST_IDX) begin
              tag_q   <= req_tag;
              valid_q <= 1'b1;
              state_q <= LOOKUP;
            end
          end
        end

        RESPOND: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sd_read_data = rdata_q;
  assign sd_ready     = ready_q;
  assign blk_addr     = blk_addr_q;
  assign blk_cmd_rd   = cmd_rd_q;

`ifdef SD_CACHE_WRITEBACK_EN
  assign blk_cmd_wr   = cmd_wr_q;
  assign blk_tx_data  = tx_data_q;
`else
  assign blk_cmd_wr   = 1'b0;
  assign blk_tx_data  = 8'h00;
`endif

endmodule

// File: tb/tb_sd_sector_cache.sv
// Testbench for sd_sector_cache: a behavioural SPI sector controller with a
// small card image drives the downstream side; the dispatcher side is checked
// against a sector-level model of what the cache should hold and do.

module tb_sd_sector_cache;

`ifdef SD_CACHE_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        sd_read;
  logic        sd_write;
  logic [31:0] sd_addr;
  logic [7:0]  sd_write_data;
  logic [7:0]  sd_read_data;
  logic        sd_ready;
  logic [22:0] blk_addr;
  logic        blk_cmd_rd;
  logic        blk_cmd_wr;
  logic        blk_idle;
  logic        blk_rx_valid;
  logic [7:0]  blk_rx_data;
  logic        blk_tx_req;
  logic [7:0]  blk_tx_data;
  logic        blk_err;

  sd_sector_cache dut (
    .clk           (clk),
    .reset         (reset),
    .sd_read       (sd_read),
    .sd_write      (sd_write),
    .sd_addr       (sd_addr),
    .sd_write_data (sd_write_data),
    .sd_read_data  (sd_read_data),
    .sd_ready      (sd_ready),
    .blk_addr      (blk_addr),
    .blk_cmd_rd    (blk_cmd_rd),
    .blk_cmd_wr    (blk_cmd_wr),
    .blk_idle      (blk_idle),
    .blk_rx_valid  (blk_rx_valid),
    .blk_rx_data   (blk_rx_data),
    .blk_tx_req    (blk_tx_req),
    .blk_tx_data   (blk_tx_data),
    .blk_err       (blk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Card image and controller bookkeeping
  logic [7:0]  card [0:7][0:511];
  logic [7:0]  wbuf [0:511];
  int          n_cmd_rd = 0;
  int          n_cmd_wr = 0;
  logic [22:0] c_rd_addr;
  logic [22:0] c_wr_addr;
  logic [22:0] c_sec;
  int          c_mode = 0;
  int          c_idx  = 0;
  bit          c_pend = 1'b0;
  bit          c_err_armed = 1'b0;
  int          c_err_at = 0;

  // Reference model: byte-addressed memory as the dispatcher should see it
  logic [7:0]  model_mem [0:4095];
  bit          m_valid;
  bit          m_dirty;
  int          m_sec;
  logic [7:0]  m_rdata;

  function automatic logic [7:0] card_init(input int s, input int i);
    return 8'(i + 17 * (s - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural sector controller, acting on falling edges
  initial begin
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 512; i++)
        card[s][i] = card_init(s, i);
    blk_idle     = 1'b1;
    blk_rx_valid = 1'b0;
    blk_rx_data  = 8'h00;
    blk_tx_req   = 1'b0;
    blk_err      = 1'b0;
    forever begin
      @(negedge clk);
      blk_rx_valid = 1'b0;
      blk_tx_req   = 1'b0;
      blk_err      = 1'b0;
      if (reset) begin
        c_mode   = 0;
        c_pend   = 1'b0;
        blk_idle = 1'b1;
      end else begin
        case (c_mode)
          0: begin
            blk_idle = 1'b1;
            if (blk_cmd_rd) begin
              n_cmd_rd++;
              c_rd_addr = blk_addr;
              c_sec     = blk_addr;
              c_idx     = 0;
              c_mode    = 1;
              blk_idle  = 1'b0;
            end else if (blk_cmd_wr) begin
              n_cmd_wr++;
              c_wr_addr = blk_addr;
              c_sec     = blk_addr;
              c_idx     = 0;
              c_pend    = 1'b0;
              c_mode    = 2;
              blk_idle  = 1'b0;
            end
          end
          1: begin
            if ($urandom_range(0, 3) != 0) begin
              if (c_err_armed && c_idx == c_err_at) begin
                blk_err     = 1'b1;
                c_err_armed = 1'b0;
                c_mode      = 0;
              end else begin
                blk_rx_valid = 1'b1;
                blk_rx_data  = card[c_sec[2:0]][c_idx];
                c_idx++;
                if (c_idx == 512) c_mode = 0;
              end
            end
          end
          default: begin
            if (c_pend) begin
              wbuf[c_idx] = blk_tx_data;
              c_idx++;
              c_pend = 1'b0;
            end
            if (c_idx == 512) begin
              for (int i = 0; i < 512; i++) card[c_sec[2:0]][i] = wbuf[i];
              c_mode = 0;
            end else if ($urandom_range(0, 3) != 0) begin
              blk_tx_req = 1'b1;
              c_pend     = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // One dispatcher access, checked against the model; err_at >= 0 injects blk_err
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [7:0] d, input int err_at);
    int sec, old_sec, lat, rd0, wr0, nbad;
    bit is_rd, hit, exp_fill, exp_wb, got, err;
    sec      = int'(a >> 9);
    is_rd    = rd;
    err      = (err_at >= 0);
    hit      = m_valid && (m_sec == sec);
    exp_fill = !hit && (is_rd || WB);
    exp_wb   = exp_fill && m_dirty;
    old_sec  = m_sec;
    rd0      = n_cmd_rd;
    wr0      = n_cmd_wr;
    if (err) begin
      c_err_at    = err_at;
      c_err_armed = 1'b1;
    end
    @(negedge clk);
    sd_read       = rd;
    sd_write      = wr;
    sd_addr       = a;
    sd_write_data = d;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 6000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        sd_read  = 1'b0;
        sd_write = 1'b0;
      end
      got = sd_ready;
    end
    chk("ready_seen", 32'(got), 32'd1);
    if (!exp_fill) chk("hit_latency", 32'(lat), 32'd2);
    chk("cmd_rd_count", 32'(n_cmd_rd - rd0), 32'(exp_fill));
    if (exp_fill) chk("cmd_rd_addr", 32'(c_rd_addr), 32'(sec));
    chk("cmd_wr_count", 32'(n_cmd_wr - wr0), 32'(exp_wb));
    if (exp_wb) begin
      chk("cmd_wr_addr", 32'(c_wr_addr), 32'(old_sec));
      nbad = 0;
      for (int i = 0; i < 512; i++)
        if (card[old_sec][i] !== model_mem[old_sec * 512 + i]) nbad++;
      chk("wb_content", 32'(nbad), 32'd0);
      m_dirty = 1'b0;
    end
    if (err) begin
      chk("err_injected", 32'(c_err_armed), 32'd0);
      m_rdata = 8'hFF;
    end else if (is_rd) begin
      m_rdata = model_mem[a[11:0]];
    end
    chk("read_data", 32'(sd_read_data), 32'(m_rdata));
    @(negedge clk);
    chk("ready_pulse", 32'(sd_ready), 32'd0);
    if (exp_fill) begin
      m_valid = !err;
      m_sec   = sec;
    end
    if (WB && !is_rd && !err) begin
      model_mem[a[11:0]] = d;
      m_dirty = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},    32'(sd_ready),     32'd0);
    chk({tag, "_rdata"},    32'(sd_read_data), 32'd0);
    chk({tag, "_cmd_rd"},   32'(blk_cmd_rd),   32'd0);
    chk({tag, "_cmd_wr"},   32'(blk_cmd_wr),   32'd0);
    chk({tag, "_blk_addr"}, 32'(blk_addr),     32'd0);
    chk({tag, "_tx_data"},  32'(blk_tx_data),  32'd0);
  endtask

  // Assert reset once the fill of address a has reached byte 'at'
  task automatic reset_mid_fill(input logic [31:0] a, input int at);
    int waited, rd0, wr0, readies;
    rd0 = n_cmd_rd;
    @(negedge clk);
    sd_read = 1'b1;
    sd_addr = a;
    @(negedge clk);
    sd_read = 1'b0;
    waited = 0;
    while (!(c_mode == 1 && c_idx >= at) && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    chk("fill_reached", 32'(c_mode == 1 && c_idx >= at), 32'd1);
    chk("fill_cmd_issued", 32'(n_cmd_rd - rd0), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    reset = 1'b0;
    m_valid = 1'b0;
    m_dirty = 1'b0;
    m_rdata = 8'h00;
    rd0 = n_cmd_rd;
    wr0 = n_cmd_wr;
    readies = 0;
    repeat (20) begin
      @(negedge clk);
      if (sd_ready) readies++;
    end
    chk("quiet_cmd_rd", 32'(n_cmd_rd - rd0), 32'd0);
    chk("quiet_cmd_wr", 32'(n_cmd_wr - wr0), 32'd0);
    chk("quiet_ready", 32'(readies), 32'd0);
  endtask

  initial begin
    int rd0, t, ready_t0, ready_t1, nready;
    logic [7:0] d0, d1;
    logic [31:0] a;
    int op;

    reset         = 1'b1;
    sd_read       = 1'b0;
    sd_write      = 1'b0;
    sd_addr       = '0;
    sd_write_data = '0;
    for (int i = 0; i < 4096; i++) model_mem[i] = card_init(i / 512, i % 512);
    m_valid = 1'b0;
    m_dirty = 1'b0;
    m_sec   = 0;
    m_rdata = 8'h00;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Cold read of sector 1: byte i of sector 1 is i, so 0x203 returns 0x03
    access(1'b1, 1'b0, 32'h0000_0203, 8'h00, -1);
    chk("first_read_value", 32'(sd_read_data), 32'h03);

    // Held read: two responses, at 2 and 5 cycles after first sample
    rd0 = n_cmd_rd;
    @(negedge clk);
    sd_read = 1'b1;
    sd_addr = 32'h0000_02FF;
    nready = 0;
    ready_t0 = 0;
    ready_t1 = 0;
    d0 = 8'h00;
    d1 = 8'h00;
    for (t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (t == 4) sd_read = 1'b0;
      if (sd_ready) begin
        if (nready == 0) begin ready_t0 = t; d0 = sd_read_data; end
        else begin ready_t1 = t; d1 = sd_read_data; end
        nready++;
      end
    end
    chk("held_ready_count", 32'(nready), 32'd2);
    chk("held_ready_t0", 32'(ready_t0), 32'd2);
    chk("held_ready_t1", 32'(ready_t1), 32'd5);
    chk("held_data0", 32'(d0), 32'hFF);
    chk("held_data1", 32'(d1), 32'hFF);
    chk("held_no_cmd_rd", 32'(n_cmd_rd - rd0), 32'd0);
    m_rdata = 8'hFF;

    // Write hit, read it back, then read+write together on a hit
    access(1'b0, 1'b1, 32'h0000_0205, 8'hA5, -1);
    access(1'b1, 1'b0, 32'h0000_0205, 8'h00, -1);
    chk("write_readback", 32'(sd_read_data), WB ? 32'hA5 : 32'h05);
    access(1'b1, 1'b1, 32'h0000_0206, 8'h11, -1);
    access(1'b1, 1'b0, 32'h0000_0206, 8'h00, -1);
    chk("both_high_buffer", 32'(sd_read_data), 32'h06);

    // Miss to sector 2: write-back of sector 1 first when writes are cached
    access(1'b1, 1'b0, 32'h0000_0400, 8'h00, -1);
    chk("wb_byte5", 32'(card[1][5]), WB ? 32'hA5 : 32'h05);

    // Transfer error at fill byte 100, then the same sector is re-fetched
    access(1'b1, 1'b0, 32'h0000_0600, 8'h00, 100);
    access(1'b1, 1'b0, 32'h0000_0600, 8'h00, -1);

    // Reset in the middle of a fill, then a fresh fetch
    reset_mid_fill(32'h0000_0800, 300);
    access(1'b1, 1'b0, 32'h0000_0801, 8'h00, -1);

    // Random mix of reads, writes and read+write over sectors 0..3
    for (int n = 0; n < 24; n++) begin
      a  = 32'($urandom_range(0, 3) * 512 + $urandom_range(0, 511));
      op = int'($urandom_range(0, 2));
      access(op != 1, op != 0, a, 8'($urandom_range(0, 255)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
